// File: rtl/wb_stage_reg_pkg.sv
// Shared pipeline definitions for the WB->ID register: reset PC, mem2reg encodings,
// bubble field values and the register-write qualification helper.
package wb_stage_reg_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_PC8 = 2'b10
  } mem2reg_e;

  localparam logic       BUBBLE_VALID    = 1'b0;
  localparam logic       BUBBLE_REGWRITE = 1'b0;
  localparam logic [1:0] BUBBLE_MEM2REG  = M2R_ALU;

  // Writes to $0 and writes from empty slots must never reach the register file.
  function automatic logic qual_regwrite(input logic valid, input logic regwrite,
                                         input logic addr_is_zero);
    return valid & regwrite & ~addr_is_zero;
  endfunction

endpackage

// File: rtl/wb_stage_reg_fwd_match.sv
// One forwarding lookup port: matches a requested register against the retiring write.
module fwd_match #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              valid,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [DATA_W-1:0] result,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic hit_s;

  // Compare and gate the forwarded value so a miss always presents zero.
  always_comb begin
    hit_s = valid & regwrite & (wraddr == addr);
    if (hit_s) begin
      data = result;
    end else begin
      data = {DATA_W{1'b0}};
    end
  end

  assign hit = hit_s;

endmodule

// File: rtl/wb_stage_reg.sv
// WB->ID pipeline register with stall/flush, $0 write suppression, forwarding
// lookup ports and a retired-instruction counter.
module wb_stage_reg
  import wb_stage_reg_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 5,
  parameter int              NFWD     = 2,
  parameter int              RETIRE_W = 32,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_regwrite,
  input  logic [1:0]               in_mem2reg,
  input  logic [ADDR_W-1:0]        in_wraddr,
  input  logic [DATA_W-1:0]        in_instr,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]        in_pc8,
  output logic                     out_valid,
  output logic                     out_regwrite,
  output logic [1:0]               out_mem2reg,
  output logic [ADDR_W-1:0]        out_wraddr,
  output logic [DATA_W-1:0]        out_instr,
  output logic [DATA_W-1:0]        out_result,
  output logic [DATA_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_pc8,
  input  logic [NFWD*ADDR_W-1:0]   fwd_addr,
  output logic [NFWD-1:0]          fwd_hit,
  output logic [NFWD*DATA_W-1:0]   fwd_data,
  output logic [RETIRE_W-1:0]      retired
);

  logic load_regwrite_s;
  logic count_en_s;

  assign load_regwrite_s = qual_regwrite(in_valid, in_regwrite,
                                         (in_wraddr == {ADDR_W{1'b0}}));
  // Flush squashes the incoming slot only, so the outgoing one still retires.
  assign count_en_s = out_valid & (~stall | flush);

  // Payload registers and retire counter; priority reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= BUBBLE_VALID;
      out_regwrite <= BUBBLE_REGWRITE;
      out_mem2reg  <= BUBBLE_MEM2REG;
      out_wraddr   <= {ADDR_W{1'b0}};
      out_instr    <= {DATA_W{1'b0}};
      out_result   <= {DATA_W{1'b0}};
      out_pc       <= PC_RESET;
      out_pc8      <= PC_RESET;
      retired      <= {RETIRE_W{1'b0}};
    end else begin
      if (count_en_s) begin
        retired <= retired + RETIRE_W'(1);
      end
      if (flush) begin
        out_valid    <= BUBBLE_VALID;
        out_regwrite <= BUBBLE_REGWRITE;
        out_mem2reg  <= BUBBLE_MEM2REG;
        out_wraddr   <= {ADDR_W{1'b0}};
        out_instr    <= {DATA_W{1'b0}};
        out_result   <= {DATA_W{1'b0}};
        out_pc       <= PC_RESET;
        out_pc8      <= PC_RESET;
      end else if (!stall) begin
        out_valid    <= in_valid;
        out_regwrite <= load_regwrite_s;
        out_mem2reg  <= in_mem2reg;
        out_wraddr   <= in_wraddr;
        out_instr    <= in_instr;
        out_result   <= in_result;
        out_pc       <= in_pc;
        out_pc8      <= in_pc8;
      end
    end
  end

  for (genvar i = 0; i < NFWD; i++) begin : g_fwd
    fwd_match #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_fwd_match (
      .addr    (fwd_addr[i*ADDR_W +: ADDR_W]),
      .valid   (out_valid),
      .regwrite(out_regwrite),
      .wraddr  (out_wraddr),
      .result  (out_result),
      .hit     (fwd_hit[i]),
      .data    (fwd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_wb_stage_reg.sv
// Self-checking bench for wb_stage_reg: vector table plus hand sequences, scoreboard-checked.
module tb_wb_stage_reg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NFWD     = 2;
  localparam int RETIRE_W = 4;

  logic clk = 1'b0;
  logic reset, stall, flush, in_valid, in_regwrite;
  logic [1:0] in_mem2reg;
  logic [ADDR_W-1:0] in_wraddr;
  logic [DATA_W-1:0] in_instr, in_result, in_pc, in_pc8;
  logic out_valid, out_regwrite;
  logic [1:0] out_mem2reg;
  logic [ADDR_W-1:0] out_wraddr;
  logic [DATA_W-1:0] out_instr, out_result, out_pc, out_pc8;
  logic [NFWD*ADDR_W-1:0] fwd_addr;
  logic [NFWD-1:0] fwd_hit;
  logic [NFWD*DATA_W-1:0] fwd_data;
  logic [RETIRE_W-1:0] retired;

  always #5 clk = ~clk;

  wb_stage_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NFWD(NFWD), .RETIRE_W(RETIRE_W),
    .PC_RESET(32'h0000_3000)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_mem2reg(in_mem2reg),
    .in_wraddr(in_wraddr), .in_instr(in_instr), .in_result(in_result),
    .in_pc(in_pc), .in_pc8(in_pc8),
    .out_valid(out_valid), .out_regwrite(out_regwrite), .out_mem2reg(out_mem2reg),
    .out_wraddr(out_wraddr), .out_instr(out_instr), .out_result(out_result),
    .out_pc(out_pc), .out_pc8(out_pc8),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retired(retired)
  );

  typedef struct {
    logic reset, stall, flush, valid, regwrite;
    logic [1:0] m2r;
    logic [4:0] wa;
    logic [31:0] instr, result, pc;
    logic [4:0] fa0, fa1;
  } stim_t;

  typedef struct {
    logic valid, regwrite;
    logic [1:0] m2r;
    logic [4:0] wa;
    logic [31:0] instr, result, pc, pc8;
    logic [1:0] hit;
    logic [31:0] d0, d1;
    logic [3:0] retired;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  vec_t vt[14];

  function automatic stim_t mk_s(logic r, logic st, logic fl, logic v, logic rw,
                                 logic [1:0] m2r, logic [4:0] wa, logic [31:0] instr,
                                 logic [31:0] result, logic [31:0] pc,
                                 logic [4:0] fa0, logic [4:0] fa1);
    stim_t s;
    s.reset = r; s.stall = st; s.flush = fl; s.valid = v; s.regwrite = rw;
    s.m2r = m2r; s.wa = wa; s.instr = instr; s.result = result; s.pc = pc;
    s.fa0 = fa0; s.fa1 = fa1;
    return s;
  endfunction

  function automatic exp_t mk_e(logic v, logic rw, logic [1:0] m2r, logic [4:0] wa,
                                logic [31:0] instr, logic [31:0] result, logic [31:0] pc,
                                logic [1:0] hit, logic [31:0] d0, logic [31:0] d1,
                                logic [3:0] ret);
    exp_t e;
    e.valid = v; e.regwrite = rw; e.m2r = m2r; e.wa = wa; e.instr = instr;
    e.result = result; e.pc = pc; e.pc8 = pc + 32'd8; e.hit = hit;
    e.d0 = d0; e.d1 = d1; e.retired = ret;
    return e;
  endfunction

  function automatic exp_t bubble_e(logic [3:0] ret);
    exp_t e;
    e = mk_e(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'h0000_3000, 2'b00, 32'd0, 32'd0, ret);
    e.pc8 = 32'h0000_3000;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input stim_t s, input exp_t e, input string nm);
    exp_t ex;
    reset = s.reset; stall = s.stall; flush = s.flush;
    in_valid = s.valid; in_regwrite = s.regwrite; in_mem2reg = s.m2r;
    in_wraddr = s.wa; in_instr = s.instr; in_result = s.result;
    in_pc = s.pc; in_pc8 = s.pc + 32'd8;
    fwd_addr = {s.fa1, s.fa0};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      ex = exp_q.pop_front();
      chk({nm, ".valid"},    {31'd0, out_valid},    {31'd0, ex.valid});
      chk({nm, ".regwrite"}, {31'd0, out_regwrite}, {31'd0, ex.regwrite});
      chk({nm, ".mem2reg"},  {30'd0, out_mem2reg},  {30'd0, ex.m2r});
      chk({nm, ".wraddr"},   {27'd0, out_wraddr},   {27'd0, ex.wa});
      chk({nm, ".instr"},    out_instr,  ex.instr);
      chk({nm, ".result"},   out_result, ex.result);
      chk({nm, ".pc"},       out_pc,     ex.pc);
      chk({nm, ".pc8"},      out_pc8,    ex.pc8);
      chk({nm, ".fwd_hit"},  {30'd0, fwd_hit}, {30'd0, ex.hit});
      chk({nm, ".fwd_data0"}, fwd_data[31:0],  ex.d0);
      chk({nm, ".fwd_data1"}, fwd_data[63:32], ex.d1);
      chk({nm, ".retired"},  {28'd0, retired}, {28'd0, ex.retired});
    end
  endtask

  initial begin
    exp_t a_e;
    a_e = mk_e(1'b1, 1'b1, 2'b10, 5'd31, 32'h66, 32'h0F0F_0F0F, 32'h3018,
               2'b01, 32'h0F0F_0F0F, 32'd0, 4'd3);

    vt[0]  = '{mk_s(1,0,0,0,0,2'b00,5'd0,32'h0,32'h0,32'h0,5'd0,5'd0), bubble_e(4'd0)};
    vt[1]  = '{mk_s(1,0,0,0,0,2'b00,5'd0,32'h0,32'h0,32'h0,5'd0,5'd0), bubble_e(4'd0)};
    vt[2]  = '{mk_s(0,0,0,1,1,2'b00,5'd5,32'h11,32'hDEAD_BEEF,32'h3004,5'd5,5'd6),
               mk_e(1,1,2'b00,5'd5,32'h11,32'hDEAD_BEEF,32'h3004,2'b01,32'hDEAD_BEEF,32'd0,4'd0)};
    vt[3]  = '{mk_s(0,0,0,1,1,2'b01,5'd0,32'h22,32'h1234_5678,32'h3008,5'd0,5'd5),
               mk_e(1,0,2'b01,5'd0,32'h22,32'h1234_5678,32'h3008,2'b00,32'd0,32'd0,4'd1)};
    vt[4]  = '{mk_s(0,0,0,0,1,2'b10,5'd7,32'h33,32'hAAAA_5555,32'h300C,5'd7,5'd7),
               mk_e(0,0,2'b10,5'd7,32'h33,32'hAAAA_5555,32'h300C,2'b00,32'd0,32'd0,4'd2)};
    vt[5]  = '{mk_s(0,0,0,1,1,2'b11,5'd3,32'h44,32'hCAFE_F00D,32'h3010,5'd3,5'd3),
               mk_e(1,1,2'b11,5'd3,32'h44,32'hCAFE_F00D,32'h3010,2'b11,32'hCAFE_F00D,32'hCAFE_F00D,4'd2)};
    vt[6]  = '{mk_s(0,0,1,1,1,2'b01,5'd9,32'h55,32'h9999_9999,32'h3014,5'd3,5'd9), bubble_e(4'd3)};
    vt[7]  = '{mk_s(0,0,0,1,1,2'b10,5'd31,32'h66,32'h0F0F_0F0F,32'h3018,5'd31,5'd30), a_e};
    vt[8]  = '{mk_s(0,1,0,1,1,2'b01,5'd4,32'h77,32'h1111_1111,32'h301C,5'd31,5'd4), a_e};
    vt[9]  = '{mk_s(0,1,0,0,0,2'b00,5'd6,32'h78,32'h2222_2222,32'h3020,5'd31,5'd4), a_e};
    vt[10] = '{mk_s(0,1,0,1,1,2'b11,5'd8,32'h79,32'h3333_3333,32'h3024,5'd31,5'd4), a_e};
    vt[11] = '{mk_s(0,1,1,1,1,2'b00,5'd6,32'h88,32'h4444_4444,32'h3028,5'd31,5'd6), bubble_e(4'd4)};
    vt[12] = '{mk_s(0,1,0,1,1,2'b00,5'd6,32'h89,32'h5555_5555,32'h302C,5'd31,5'd6), bubble_e(4'd4)};
    vt[13] = '{mk_s(0,0,0,1,1,2'b00,5'd2,32'h99,32'h1357_2468,32'h3030,5'd2,5'd2),
               mk_e(1,1,2'b00,5'd2,32'h99,32'h1357_2468,32'h3030,2'b11,32'h1357_2468,32'h1357_2468,4'd4)};

    for (int i = 0; i < 14; i++) begin
      apply(vt[i].s, vt[i].e, $sformatf("vec%0d", i));
    end

    // Reset while stalled with a valid instruction in flight.
    apply(mk_s(1,1,0,1,1,2'b01,5'd8,32'hAB,32'h7777_7777,32'h3034,5'd2,5'd8),
          bubble_e(4'd0), "reset_mid");

    // Seventeen consecutive retirements, then a flush edge: counter wraps to 1.
    for (int k = 1; k <= 17; k++) begin
      logic [4:0]  wa;
      logic [31:0] res;
      logic [31:0] pc;
      logic [3:0]  ret;
      wa  = 5'(k);
      res = 32'h1000 + 32'(k);
      pc  = 32'h3000 + 32'(4 * k);
      ret = 4'(k - 1);
      apply(mk_s(0,0,0,1,1,2'b01,wa,32'(k),res,pc,wa,wa),
            mk_e(1,1,2'b01,wa,32'(k),res,pc,2'b11,res,res,ret), $sformatf("wrap%0d", k));
    end
    apply(mk_s(0,0,1,1,1,2'b00,5'd1,32'h0,32'h0,32'h0,5'd1,5'd1), bubble_e(4'd1), "wrap_flush");

    apply(mk_s(0,0,0,1,1,2'b10,5'd12,32'hC0,32'h0BAD_CAFE,32'h3100,5'd12,5'd0),
          mk_e(1,1,2'b10,5'd12,32'hC0,32'h0BAD_CAFE,32'h3100,2'b01,32'h0BAD_CAFE,32'd0,4'd1),
          "pre_reset");
    apply(mk_s(1,1,1,1,1,2'b01,5'd13,32'hC1,32'h1,32'h3104,5'd12,5'd13), bubble_e(4'd0),
          "reset_stall_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
